// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: drives a single 7-segment digit with a repeating frame.
// Frame order: tens digit, blank gap, ones digit with decimal point, blank pause.
// The value shown comes from the bin2dec converter. This block feeds o_bin and
// o_tens/o_ones to the converter and gets the selected BCD digit back on i_dec.
module digit_scan_ctrl #(
    parameter int DIGIT_CYCLES = 1024,
    parameter int GAP_CYCLES   = 256,
    parameter int PAUSE_CYCLES = 2048,
    parameter int CNT_W        = 12,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_result,
    input  logic       i_result_valid,
    input  logic       i_hold,
    input  logic [3:0] i_dec,
    output logic [5:0] o_bin,
    output logic       o_tens,
    output logic       o_ones,
    output logic [6:0] o_seg,
    output logic       o_dp
);

    typedef enum logic [1:0] {S_TENS, S_GAP, S_ONES, S_PAUSE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, last_cnt;
    logic [5:0]       bin_q, bin_d, pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_start, capture;

    // Segment encoding, gfedcba. Codes that are not BCD are shown blank.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Dwell length for each state, expressed as the final count value.
    always_comb begin
        last_cnt = CNT_W'(PAUSE_CYCLES - 1);
        case (state_q)
            S_TENS:  last_cnt = CNT_W'(DIGIT_CYCLES - 1);
            S_GAP:   last_cnt = CNT_W'(GAP_CYCLES - 1);
            S_ONES:  last_cnt = CNT_W'(DIGIT_CYCLES - 1);
            default: last_cnt = CNT_W'(PAUSE_CYCLES - 1);
        endcase
    end

    assign frame_start = (state_q == S_PAUSE) && (cnt_q == last_cnt);
    assign capture     = i_result_valid && !i_hold;

    // Next state and dwell count. The state advances on the final count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == last_cnt) begin
            cnt_d = '0;
            case (state_q)
                S_TENS:  state_d = S_GAP;
                S_GAP:   state_d = S_ONES;
                S_ONES:  state_d = S_PAUSE;
                default: state_d = S_TENS;
            endcase
        end
    end

    // Result capture and frame load. o_bin changes only at a frame start, so
    // both digits of a frame always come from the same value.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        bin_d      = bin_q;
        if (frame_start) begin
            if (capture) begin
                bin_d      = i_result;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                bin_d      = pend_q;
                pend_vld_d = 1'b0;
            end
        end else if (capture) begin
            pend_d     = i_result;
            pend_vld_d = 1'b1;
        end
    end

    // Segment drive. The tens slot is blanked for a leading zero.
    always_comb begin
        seg_d = '0;
        dp_d  = (state_q == S_ONES);
        if ((state_q == S_ONES) ||
            ((state_q == S_TENS) && !(BLANK_LZ && (i_dec == 4'd0))))
            seg_d = enc(i_dec);
    end

    // State registers. Reset puts the sequencer at the start of a full pause.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_PAUSE;
            cnt_q      <= '0;
            bin_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            seg_q      <= '0;
            dp_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign o_bin  = bin_q;
    assign o_tens = (state_q == S_TENS);
    assign o_ones = (state_q == S_ONES);
    assign o_seg  = seg_q;
    assign o_dp   = dp_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl. A bin2dec model is wired in the loop.
// The stimulus pushes one expected frame (value, tens segs, ones segs) per frame.
// The monitor records each complete frame it sees and pops an entry to compare.
module tb_digit_scan_ctrl;

    localparam int DIG   = 4;
    localparam int GAP   = 2;
    localparam int PAU   = 3;
    localparam int FRAME = 2 * DIG + GAP + PAU;   // 13
    localparam int T0    = 2;                     // edge index of the last reset edge

    logic       clk = 1'b0;
    logic       i_reset, i_result_valid, i_hold;
    logic [5:0] i_result;
    logic [3:0] i_dec;
    logic [5:0] o_bin;
    logic       o_tens, o_ones, o_dp;
    logic [6:0] o_seg;

    digit_scan_ctrl #(
        .DIGIT_CYCLES(DIG), .GAP_CYCLES(GAP), .PAUSE_CYCLES(PAU),
        .CNT_W(12), .BLANK_LZ(1'b1)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_result(i_result),
        .i_result_valid(i_result_valid), .i_hold(i_hold), .i_dec(i_dec),
        .o_bin(o_bin), .o_tens(o_tens), .o_ones(o_ones), .o_seg(o_seg), .o_dp(o_dp)
    );

    always #5 clk = ~clk;

    // bin2dec model: selected decimal digit of o_bin
    always_comb begin
        i_dec = 4'd0;
        if (o_tens)      i_dec = 4'(o_bin / 6'd10);
        else if (o_ones) i_dec = 4'(o_bin % 6'd10);
    end

    typedef struct {
        int bin;
        int tseg;
        int oseg;
        bit lat;
    } exp_t;
    exp_t exp_q[$];

    int npass = 0, ntot = 0;
    int ecnt = 0;
    int since;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        ntot++;
        if (act === req) npass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic push(input int bin, input int ts, input int os, input bit lat);
        exp_t e;
        e.bin = bin; e.tseg = ts; e.oseg = os; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        ecnt++;
        #1;
    endtask

    task automatic at(input int n);
        while (ecnt < T0 + n) step();
    endtask

    task automatic strobe(input int v);
        i_result = 6'(v);
        i_result_valid = 1'b1;
        step();
        i_result_valid = 1'b0;
    endtask

    // cycles since the last edge at which reset was sampled
    always @(posedge clk) since <= i_reset ? 0 : since + 1;

    // monitor: record a frame from the o_tens rise through 13 more cycles
    bit         in_frame = 0, prev_tens = 0, bin_chg;
    int         pos, fsince, fbin;
    logic [7:0] seg_log [0:FRAME];
    bit         dp_log  [0:FRAME];
    bit         tn_log  [0:FRAME];
    bit         on_log  [0:FRAME];

    task automatic finish_frame();
        exp_t e;
        logic [127:0] sa, se, da, de, ta, te, oa, oe;
        if (exp_q.size() == 0) begin
            chk("unexpected frame, o_bin", 128'(fbin), 128'hFFFF);
            return;
        end
        e = exp_q.pop_front();
        sa = '0; se = '0; da = '0; de = '0; ta = '0; te = '0; oa = '0; oe = '0;
        for (int p = 1; p <= FRAME; p++) begin
            sa[p*8 +: 8] = seg_log[p];
            da[p] = dp_log[p];
            if (p >= 1 && p <= DIG) se[p*8 +: 8] = 8'(e.tseg);
            if (p >= DIG + GAP + 1 && p <= 2*DIG + GAP) begin
                se[p*8 +: 8] = 8'(e.oseg);
                de[p] = 1'b1;
            end
        end
        for (int p = 0; p < FRAME; p++) begin
            ta[p] = tn_log[p];
            oa[p] = on_log[p];
            te[p] = (p < DIG);
            oe[p] = (p >= DIG + GAP) && (p < 2*DIG + GAP);
        end
        chk("frame o_bin", 128'(fbin), 128'(e.bin));
        chk("frame o_seg sequence", sa, se);
        chk("frame o_dp sequence", da, de);
        chk("frame o_tens sequence", ta, te);
        chk("frame o_ones sequence", oa, oe);
        chk("frame o_bin stable", 128'(bin_chg), 128'(0));
        if (e.lat) chk("reset to tens latency", 128'(fsince), 128'(PAU));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (since == 0) begin
                in_frame  = 0;
                prev_tens = 0;
            end else begin
                if (o_tens && o_ones) chk("o_tens/o_ones exclusive", 128'(1), 128'(0));
                if (in_frame) begin
                    pos++;
                    seg_log[pos] = {1'b0, o_seg};
                    dp_log[pos]  = o_dp;
                    tn_log[pos]  = o_tens;
                    on_log[pos]  = o_ones;
                    if (pos < FRAME && o_bin != 6'(fbin)) bin_chg = 1;
                    if (pos == FRAME) begin
                        finish_frame();
                        in_frame = 0;
                    end
                end
                if (o_tens && !prev_tens) begin
                    in_frame  = 1;
                    pos       = 0;
                    bin_chg   = 0;
                    fbin      = int'(o_bin);
                    fsince    = since;
                    seg_log[0] = {1'b0, o_seg};
                    dp_log[0]  = o_dp;
                    tn_log[0]  = o_tens;
                    on_log[0]  = o_ones;
                end
                prev_tens = o_tens;
            end
        end
    end

    // stimulus, timed in edges after the last reset edge; frame k starts at 3+13k
    initial begin
        i_reset = 1'b1; i_result = '0; i_result_valid = 1'b0; i_hold = 1'b0;
        step(); step();
        i_reset = 1'b0;
        chk("reset o_seg",  128'(o_seg),  128'(0));
        chk("reset o_dp",   128'(o_dp),   128'(0));
        chk("reset o_tens", 128'(o_tens), 128'(0));
        chk("reset o_ones", 128'(o_ones), 128'(0));
        chk("reset o_bin",  128'(o_bin),  128'(0));
        push(0, 8'h00, 8'h3F, 1);          // frame 0: blank tens, "0"

        at(13);  strobe(42); push(42, 8'h66, 8'h5B, 0);
        at(26);  strobe(7);  push(7,  8'h00, 8'h07, 0);
        at(39);  strobe(63); push(63, 8'h7D, 8'h4F, 0);
        at(52);  strobe(42); push(42, 8'h66, 8'h5B, 0);   // frame 4
        at(62);  strobe(15);                              // during ones of frame 4
        at(66);  strobe(23); push(23, 8'h5B, 8'h4F, 0);   // frame 5
        at(80);  strobe(30); push(30, 8'h4F, 8'h3F, 0);   // sampled on the load edge
        i_hold = 1'b1;
        at(85);  strobe(55);
        push(30, 8'h4F, 8'h3F, 0);                        // frame 7
        push(30, 8'h4F, 8'h3F, 0);                        // frame 8
        at(109); i_hold = 1'b0;
        at(110); strobe(18); i_hold = 1'b1;               // pending before hold rises
        push(18, 8'h06, 8'h7F, 0);                        // frame 9
        at(133); i_hold = 1'b0;                           // frame 10 starts, gets aborted
        at(134); strobe(51);
        i_reset = 1'b1;
        step();                                           // reset sampled in S_TENS
        chk("mid reset o_seg",  128'(o_seg),  128'(0));
        chk("mid reset o_tens", 128'(o_tens), 128'(0));
        chk("mid reset o_bin",  128'(o_bin),  128'(0));
        chk("mid reset o_dp",   128'(o_dp),   128'(0));
        i_reset = 1'b0;
        push(0, 8'h00, 8'h3F, 1);                         // pending 51 lost
        push(0, 8'h00, 8'h3F, 0);
        at(170);
        chk("frames outstanding", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
